moore_seq_detector: RTL and testbench

//   Parametrised Moore serial pattern detector; successor of the team's single-bit level FSM.

---
 rtl/moore_seq_pkg.sv | 43 ++++
 rtl/moore_seq_detector_sat_counter.sv | 29 ++
 rtl/moore_seq_detector.sv | 69 ++++++
 tb/tb_moore_seq_detector.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/moore_seq_pkg.sv
// rtl/moore_seq_pkg.sv - shared constants and elaboration-time helpers for the serial pattern detector
package moore_seq_pkg;

    localparam int PAT_W_MAX = 16;
    localparam int S_IDLE    = 0;

    function automatic int state_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Longest pattern prefix that is a suffix of (matched s-bit prefix, a); seen bit j is pattern[pat_w-1-j]
    function automatic int seq_next(
        input logic [PAT_W_MAX-1:0] pattern,
        input int                   pat_w,
        input bit                   overlap,
        input int                   s,
        input bit                   a
    );
        int   best;
        int   j;
        logic ok;
        logic sb;
        if (s == pat_w && !overlap) begin
            return (a == pattern[pat_w-1]) ? 1 : 0;
        end
        best = 0;
        for (int k = 1; k <= PAT_W_MAX; k++) begin
            if (k <= pat_w && k <= s + 1) begin
                ok = 1'b1;
                for (int i = 0; i < PAT_W_MAX; i++) begin
                    if (i < k) begin
                        j  = s + 1 - k + i;
                        sb = (j == s) ? a : pattern[pat_w-1-j];
                        if (sb != pattern[pat_w-1-i]) ok = 1'b0;
                    end
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/moore_seq_detector_sat_counter.sv
// rtl/moore_seq_detector_sat_counter.sv - saturating event counter with sticky overflow flag
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (inc) begin
            if (&cnt) begin
                sat <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/moore_seq_detector.sv
// rtl/moore_seq_detector.sv - Moore serial pattern detector with saturating detection counter
module moore_seq_detector
    import moore_seq_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       a,
    input  logic                       clr,
    output logic                       out,
    output logic [$clog2(PAT_W+1)-1:0] state_o,
    output logic [CNT_W-1:0]           hit_cnt,
    output logic                       cnt_sat
);

    localparam int             SW     = state_width(PAT_W);
    localparam logic [SW-1:0]  S_FULL = SW'(PAT_W);

    logic [SW-1:0] s;
    logic [SW-1:0] s_nxt;
    logic          det;

    // Transition table is fixed at elaboration; runtime logic is only the lookup mux
    logic [SW-1:0] nxt_tbl [0:PAT_W][0:1];

    for (genvar gs = 0; gs <= PAT_W; gs++) begin : g_s
        for (genvar gb = 0; gb < 2; gb++) begin : g_b
            assign nxt_tbl[gs][gb] = SW'(seq_next(16'(PATTERN), PAT_W, OVERLAP, gs, gb != 0));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s <= SW'(S_IDLE);
        end else if (clr) begin
            s <= SW'(S_IDLE);
        end else if (en) begin
            s <= s_nxt;
        end
    end

    // A repeat full match (S_FULL -> S_FULL) is a fresh detection, not a held one
    always_comb begin
        s_nxt = SW'(S_IDLE);
        det   = 1'b0;
        s_nxt = nxt_tbl[s][a];
        det   = en && (s_nxt == S_FULL);
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (det),
        .cnt (hit_cnt),
        .sat (cnt_sat)
    );

    assign out     = (s == S_FULL);
    assign state_o = s;

endmodule

// File: tb/tb_moore_seq_detector.sv
// tb/tb_moore_seq_detector.sv - self-checking bench for moore_seq_detector in four configurations
module tb_moore_seq_detector;

    logic clk;
    logic rst;
    logic en;
    logic a;
    logic clr;

    logic       out0, out1, out2, out3;
    logic [2:0] st0, st1, st2;
    logic [0:0] st3;
    logic [7:0] hc0, hc1, hc3;
    logic [1:0] hc2;
    logic       sat0, sat1, sat2, sat3;

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

    // Configurations: 0 default, 1 non-overlapping, 2 narrow counter, 3 legacy single-bit
    int          pw [4] = '{4, 4, 4, 1};
    logic [15:0] pt [4] = '{16'hB, 16'hB, 16'hB, 16'h0};
    bit          ov [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int          cw [4] = '{8, 8, 2, 8};

    int          m_s   [4];
    int          m_cnt [4];
    bit          m_sat [4];
    logic [15:0] hist  [4];
    int          hlen  [4];

    moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .en(en), .a(a), .clr(clr),
        .out(out0), .state_o(st0), .hit_cnt(hc0), .cnt_sat(sat0));
    moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .en(en), .a(a), .clr(clr),
        .out(out1), .state_o(st1), .hit_cnt(hc1), .cnt_sat(sat1));
    moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .a(a), .clr(clr),
        .out(out2), .state_o(st2), .hit_cnt(hc2), .cnt_sat(sat2));
    moore_seq_detector #(.PAT_W(1), .PATTERN(1'b0), .OVERLAP(1'b1), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .en(en), .a(a), .clr(clr),
        .out(out3), .state_o(st3), .hit_cnt(hc3), .cnt_sat(sat3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Match length = longest pattern prefix equal to the tail of the bits seen since the last restart
    function automatic int longest(input int d);
        int  best;
        bit  ok;
        best = 0;
        for (int k = 1; k <= pw[d]; k++) begin
            if (k <= hlen[d]) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    if (hist[d][k-1-i] != pt[d][pw[d]-1-i]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    task automatic model_update();
        for (int d = 0; d < 4; d++) begin
            if (!rst || clr) begin
                m_s[d]   = 0;
                m_cnt[d] = 0;
                m_sat[d] = 1'b0;
                hist[d]  = '0;
                hlen[d]  = 0;
            end else if (en) begin
                hist[d] = {hist[d][14:0], a};
                if (hlen[d] < 16) hlen[d]++;
                m_s[d] = longest(d);
                if (m_s[d] == pw[d]) begin
                    if (m_cnt[d] == (1 << cw[d]) - 1) m_sat[d] = 1'b1;
                    else m_cnt[d]++;
                    if (!ov[d]) hlen[d] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic c, input logic e, input logic b);
        rst = r;
        clr = c;
        en  = e;
        a   = b;
        @(posedge clk);
        model_update();
        #2;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("d0_out", int'(out0), int'(m_s[0] == pw[0]));
            chk("d0_state", int'(st0), m_s[0]);
            chk("d0_cnt", int'(hc0), m_cnt[0]);
            chk("d0_sat", int'(sat0), int'(m_sat[0]));
            chk("d1_out", int'(out1), int'(m_s[1] == pw[1]));
            chk("d1_state", int'(st1), m_s[1]);
            chk("d1_cnt", int'(hc1), m_cnt[1]);
            chk("d1_sat", int'(sat1), int'(m_sat[1]));
            chk("d2_out", int'(out2), int'(m_s[2] == pw[2]));
            chk("d2_state", int'(st2), m_s[2]);
            chk("d2_cnt", int'(hc2), m_cnt[2]);
            chk("d2_sat", int'(sat2), int'(m_sat[2]));
            chk("d3_out", int'(out3), int'(m_s[3] == pw[3]));
            chk("d3_state", int'(st3), m_s[3]);
            chk("d3_cnt", int'(hc3), m_cnt[3]);
            chk("d3_sat", int'(sat3), int'(m_sat[3]));
        end
    end

    logic s1 [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic p4 [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic l6 [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic e6 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst = 1'b0;
        clr = 1'b0;
        en  = 1'b0;
        a   = 1'b0;
        do_reset();
        do_reset();
        armed = 1'b1;
        chk("reset_out", int'(out0), 0);
        chk("reset_state", int'(st0), 0);
        chk("reset_cnt", int'(hc0), 0);
        chk("reset_sat", int'(sat0), 0);

        // Contiguous stream, overlapping and non-overlapping
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, 1'b1, s1[i]);
            if (i == 3) begin
                chk("t1_d0_out_b4", int'(out0), 1);
                chk("t1_d1_out_b4", int'(out1), 1);
            end
            if (i == 4) chk("t1_d0_state_b5", int'(st0), 2);
            if (i == 6) begin
                chk("t1_d0_out_b7", int'(out0), 1);
                chk("t1_d0_cnt", int'(hc0), 2);
                chk("t1_d1_out_b7", int'(out1), 0);
                chk("t1_d1_cnt", int'(hc1), 1);
                chk("t1_d1_state_b7", int'(st1), 1);
            end
        end

        // Enable gaps between bits
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat (3) step(1'b1, 1'b0, 1'b0, ~p4[i]);
            step(1'b1, 1'b0, 1'b1, p4[i]);
        end
        chk("t3_out_b4", int'(out0), 1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_out_hold", int'(out0), 1);
        chk("t3_state_hold", int'(st0), 4);
        chk("t3_cnt", int'(hc0), 1);

        // Reset mid-sequence discards the partial match
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, p4[i]);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t4_state", int'(st0), 1);
        chk("t4_out", int'(out0), 0);
        chk("t4_cnt", int'(hc0), 0);

        // Counter saturation, then clear beats a completing bit
        do_reset();
        repeat (4) for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, p4[i]);
        chk("t5_cnt_sat_val", int'(hc2), 3);
        chk("t5_sat_flag", int'(sat2), 1);
        chk("t5_wide_cnt", int'(hc0), 4);
        chk("t5_wide_sat", int'(sat0), 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, p4[i]);
        chk("t5_state_pre_clr", int'(st2), 3);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("t5_clr_cnt", int'(hc2), 0);
        chk("t5_clr_sat", int'(sat2), 0);
        chk("t5_clr_out", int'(out2), 0);

        // Legacy single-bit mode
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, l6[i]);
            chk($sformatf("t6_out_%0d", i), int'(out3), int'(e6[i]));
        end
        chk("t6_cnt", int'(hc3), 2);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        armed = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
